// File: rtl/alarm_tune_sequencer.sv
// Alarm melody sequencer: steps the melody ROM address, gates the tone generator
// per step, repeats the tune LOOPS times, and handles snooze and stop.
module alarm_tune_sequencer #(
  parameter int TICK_DIV     = 4194304,
  parameter int GAP_DIV      = 262144,
  parameter int LOOPS        = 3,
  parameter int SNOOZE_STEPS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_trig,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic [7:0] rom_addr,
  output logic       note_gate,
  output logic       playing,
  output logic       snoozing,
  output logic [3:0] loop_idx,
  output logic       done
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_V    = DIV_W'(GAP_DIV);
  localparam logic [15:0]      SNZ_LAST = 16'(SNOOZE_STEPS - 1);
  localparam logic [3:0]       LP_LAST  = 4'(LOOPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      snz_q, snz_d;
  logic [3:0]       lp_q, lp_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic             note_gate_q, note_gate_d;
  logic             playing_q, playing_d;
  logic             snoozing_q, snoozing_d;
  logic             done_q, done_d;
  logic             step_end_s;

  // Next-state and next-output logic; outputs are derived from the next state
  // so the registered gate always matches the registered step position.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    snz_d      = snz_q;
    lp_d       = lp_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    step_end_s = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        div_d      = '0;
        snz_d      = 16'd0;
        lp_d       = 4'd0;
        rom_addr_d = 8'd0;
        if (stop_btn || snooze_btn) begin
          state_d = ST_IDLE;
        end else if (alarm_trig) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PLAY: begin
        if (stop_btn) begin
          state_d    = ST_IDLE;
          div_d      = '0;
          lp_d       = 4'd0;
          rom_addr_d = 8'd0;
        end else if (snooze_btn) begin
          state_d    = ST_SNOOZE;
          div_d      = '0;
          snz_d      = 16'd0;
          lp_d       = 4'd0;
          rom_addr_d = 8'd0;
        end else if (step_end_s) begin
          div_d = '0;
          if (rom_addr_q == 8'd255) begin
            rom_addr_d = 8'd0;
            if (lp_q == LP_LAST) begin
              state_d = ST_IDLE;
              lp_d    = 4'd0;
              done_d  = 1'b1;
            end else begin
              lp_d = lp_q + 4'd1;
            end
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_SNOOZE: begin
        rom_addr_d = 8'd0;
        if (stop_btn) begin
          state_d = ST_IDLE;
          div_d   = '0;
          snz_d   = 16'd0;
        end else if (snooze_btn) begin
          div_d = '0;
          snz_d = 16'd0;
        end else if (step_end_s) begin
          div_d = '0;
          if (snz_q == SNZ_LAST) begin
            state_d = ST_PLAY;
            snz_d   = 16'd0;
            lp_d    = 4'd0;
          end else begin
            snz_d = snz_q + 16'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        div_d      = '0;
        snz_d      = 16'd0;
        lp_d       = 4'd0;
        rom_addr_d = 8'd0;
      end
    endcase

    playing_d   = (state_d == ST_PLAY);
    snoozing_d  = (state_d == ST_SNOOZE);
    note_gate_d = playing_d && (div_d >= GAP_V);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      snz_q       <= 16'd0;
      lp_q        <= 4'd0;
      rom_addr_q  <= 8'd0;
      note_gate_q <= 1'b0;
      playing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      snz_q       <= snz_d;
      lp_q        <= lp_d;
      rom_addr_q  <= rom_addr_d;
      note_gate_q <= note_gate_d;
      playing_q   <= playing_d;
      snoozing_q  <= snoozing_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note_gate = note_gate_q;
  assign playing   = playing_q;
  assign snoozing  = snoozing_q;
  assign loop_idx  = lp_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alarm_tune_sequencer.sv
// Directed bench for alarm_tune_sequencer with TICK_DIV=8, GAP_DIV=2, LOOPS=2, SNOOZE_STEPS=4.
// Outputs are packed as {playing, snoozing, note_gate, done, loop_idx, rom_addr} and sampled on negedge.
module tb_alarm_tune_sequencer;

  logic       clk;
  logic       reset;
  logic       alarm_trig;
  logic       stop_btn;
  logic       snooze_btn;
  logic [7:0] rom_addr;
  logic       note_gate;
  logic       playing;
  logic       snoozing;
  logic [3:0] loop_idx;
  logic       done;

  int n_cmp;
  int n_bad;
  logic [15:0] got;
  logic [15:0] exp_v;

  alarm_tune_sequencer #(
    .TICK_DIV(8), .GAP_DIV(2), .LOOPS(2), .SNOOZE_STEPS(4)
  ) dut (
    .clk(clk), .reset(reset), .alarm_trig(alarm_trig), .stop_btn(stop_btn),
    .snooze_btn(snooze_btn), .rom_addr(rom_addr), .note_gate(note_gate),
    .playing(playing), .snoozing(snoozing), .loop_idx(loop_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] st();
    return {playing, snoozing, note_gate, done, loop_idx, rom_addr};
  endfunction

  function automatic logic [15:0] mk(bit p, bit s, bit g, bit d, int lp, int ra);
    return {p, s, g, d, 4'(lp), 8'(ra)};
  endfunction

  task automatic pulse_alarm();
    alarm_trig = 1'b1;
    @(negedge clk);
    alarm_trig = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_btn = 1'b1;
    @(negedge clk);
    snooze_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL reset_async: got %h expected %h", got, 16'h0000); end
    repeat (3) @(negedge clk);
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL reset_held: got %h expected %h", got, 16'h0000); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL idle_after_reset: got %h expected %h", got, 16'h0000); end
  endtask

  task automatic test_step();
    pulse_alarm();
    for (int k = 0; k < 24; k++) begin
      got = st(); exp_v = mk(1'b1, 1'b0, (k % 8) >= 2, 1'b0, 0, k / 8); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL step k=%0d: got %h expected %h", k, got, exp_v); end
      @(negedge clk);
    end
    pulse_stop();
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL step_stop: got %h expected %h", got, 16'h0000); end
  endtask

  task automatic test_full_alarm();
    pulse_alarm();
    for (int k = 0; k < 4096; k++) begin
      got = st(); exp_v = mk(1'b1, 1'b0, (k % 8) >= 2, 1'b0, k / 2048, (k / 8) % 256); n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL full k=%0d: got %h expected %h", k, got, exp_v);
      end
      @(negedge clk);
    end
    got = st(); exp_v = mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL done_pulse: got %h expected %h", got, exp_v); end
    @(negedge clk);
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL done_clear: got %h expected %h", got, 16'h0000); end
  endtask

  task automatic test_alarm_after_done();
    pulse_alarm();
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL restart_after_done: got %h expected %h", got, exp_v); end
    repeat (8) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL restart_step1: got %h expected %h", got, exp_v); end
    pulse_stop();
  endtask

  task automatic test_snooze();
    pulse_alarm();
    repeat (80) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 10); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL pre_snooze: got %h expected %h", got, exp_v); end
    pulse_snooze();
    for (int s = 0; s < 32; s++) begin
      got = st(); exp_v = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL snooze s=%0d: got %h expected %h", s, got, exp_v); end
      @(negedge clk);
    end
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL snooze_replay: got %h expected %h", got, exp_v); end
    repeat (2) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL replay_gate: got %h expected %h", got, exp_v); end
    repeat (6) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL replay_step1: got %h expected %h", got, exp_v); end
    pulse_stop();
  endtask

  task automatic test_snooze_restart();
    pulse_alarm();
    repeat (3) @(negedge clk);
    pulse_snooze();
    repeat (10) @(negedge clk);
    pulse_snooze();
    for (int t = 0; t < 32; t++) begin
      got = st(); exp_v = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL resnooze t=%0d: got %h expected %h", t, got, exp_v); end
      @(negedge clk);
    end
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL resnooze_replay: got %h expected %h", got, exp_v); end
    repeat (5) @(negedge clk);
    pulse_snooze();
    repeat (4) @(negedge clk);
    pulse_stop();
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL stop_in_snooze: got %h expected %h", got, 16'h0000); end
  endtask

  task automatic test_stop_snooze_same();
    pulse_alarm();
    repeat (12) @(negedge clk);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      got = st(); n_cmp++;
      if (got !== 16'h0000) begin n_bad++; $display("FAIL stop_wins i=%0d: got %h expected %h", i, got, 16'h0000); end
      @(negedge clk);
    end
  endtask

  task automatic test_alarm_in_play();
    pulse_alarm();
    repeat (40) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 5); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL at_addr5: got %h expected %h", got, exp_v); end
    pulse_alarm();
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 5); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL retrig_ignored: got %h expected %h", got, exp_v); end
    repeat (7) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 6); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL retrig_continue: got %h expected %h", got, exp_v); end
    pulse_stop();
  endtask

  task automatic test_reset_mid();
    pulse_alarm();
    repeat (13) @(negedge clk);
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 1); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL pre_reset: got %h expected %h", got, exp_v); end
    #2 reset = 1'b1;
    #1;
    got = st(); n_cmp++;
    if (got !== 16'h0000) begin n_bad++; $display("FAIL reset_mid_async: got %h expected %h", got, 16'h0000); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = st(); n_cmp++;
      if (got !== 16'h0000) begin n_bad++; $display("FAIL idle_after_mid i=%0d: got %h expected %h", i, got, 16'h0000); end
    end
    pulse_alarm();
    got = st(); exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL alarm_after_reset: got %h expected %h", got, exp_v); end
    pulse_stop();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    alarm_trig = 1'b0;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    #1;
    test_reset();
    test_step();
    test_full_alarm();
    test_alarm_after_done();
    test_snooze();
    test_snooze_restart();
    test_stop_snooze_same();
    test_alarm_in_play();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
